cdb_broadcaster: RTL and testbench
==================================

# cdb_broadcaster

Common Data Bus producer. Collects completed results from the functional units and broadcasts up to three (tag, value) pairs per cycle to every RS line, the ROB and the map table. Each FU has a one-entry holding register. A round-robin arbiter picks up to `CDB_WIDTH` pending results per cycle, and the CDB output is registered. The FU side uses a valid/ready handshake, so an FU that loses arbitration is back-pressured instead of dropping its result.

## Interface
- `NUM_FU`, 5, number of FU result ports (ALU0, ALU1, MULT, LOAD, BRANCH order)
- `CDB_WIDTH`, 3, broadcast slots per cycle; must be ≤ `NUM_FU`
- `TAG_W`, `$clog2(ROBLEN)`, ROB tag width
- `DATA_W`, `XLEN` (32), result width
- `clock` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-low
- `squash` in 1: synchronous flush (branch mispredict)
- `fu_valid` in `NUM_FU`: FU i presents a result
- `fu_tag` in `NUM_FU`×`TAG_W`: ROB tag of result i
- `fu_value` in `NUM_FU`×`DATA_W`: result value i
- `fu_ready` out `NUM_FU`: FU i handshake accepted this cycle
- `cdb_valid` out `CDB_WIDTH`: slot s carries a valid broadcast
- `cdb_tag` out `CDB_WIDTH`×`TAG_W`: broadcast tags
- `cdb_value` out `CDB_WIDTH`×`DATA_W`: broadcast values

## Operation
- State:
  - per-FU holding register `hold_valid[i]`, `hold_tag[i]`, `hold_value[i]`
  - round-robin pointer `rr_ptr`, range 0..`NUM_FU`-1
  - registered CDB outputs
- Arbitration (combinational, on holding registers only):
  - Scan i = `rr_ptr`, `rr_ptr`+1, … mod `NUM_FU`.
  - The first `CDB_WIDTH` entries with `hold_valid` are granted.
  - The k-th granted entry goes to slot k; slots are filled lowest-first with no gaps.
- `fu_ready[i]` = `~squash & (~hold_valid[i] | grant[i])`. It has no dependence on `fu_valid`.
- Holding update at each edge, for each i:
  - if `fu_valid[i] & fu_ready[i]`: load the new tag and value, `hold_valid`=1
  - else if `grant[i]`: `hold_valid`=0
  - else: hold
- CDB update at each edge:
  - Slot k takes the tag and value of the k-th grant, with `cdb_valid[k]`=1.
  - Unused slots have `cdb_valid`=0. Their tag and value are driven to 0.
- `rr_ptr` update:
  - If any grant: (index of last granted entry + 1) mod `NUM_FU`.
  - Otherwise unchanged.
- Squash (sync, highest priority below reset), at the next edge:
  - All `hold_valid`=0.
  - `cdb_valid`=0 and tag/value=0.
  - `rr_ptr`=0.
  - Incoming `fu_valid` in the squash cycle is dropped (`fu_ready`=0).
- Tag 0 is a legal tag. Only `cdb_valid` qualifies a slot.
- Tags on the bus are not de-duplicated. The ROB guarantees unique in-flight tags.

## Timing
- Reset (`reset`=0, async) values:
  - `cdb_valid`=0, `cdb_tag`=0, `cdb_value`=0
  - all `hold_valid`=0, `rr_ptr`=0
  - `fu_ready`=all 1, since holds are empty and `squash` is assumed 0 by the pipeline during reset
- Latency: FU handshake at edge E → captured in the holding register → if granted, the result is on the CDB after edge E+1. The minimum is 1 cycle from handshake to bus visibility.
- Throughput: one result per FU per cycle when uncontended. Grant and reload in the same cycle give no bubble.
- Contention: more than `CDB_WIDTH` pending holds → the losers keep `fu_ready`=0 and retry next cycle. Fairness is bounded: any pending entry is granted within ⌈`NUM_FU`/`CDB_WIDTH`⌉ cycles.
- Reset mid-operation: all pending results and the in-flight broadcast are discarded immediately, with no partial slot update.
- `squash` and `reset`: `reset` dominates. `squash` with no pending results is a no-op apart from `rr_ptr`=0.

## Test plan
- **Reset:** assert `reset`=0 mid-stream with 3 holds pending → `cdb_valid`=000 immediately, `fu_ready`=11111 after release, first broadcast only from new handshakes.
- **Single result:** FU2 sends tag 7, value 0xDEADBEEF at edge E → after E+1, slot0 = {1, 7, 0xDEADBEEF} and slots 1–2 invalid; `rr_ptr`=3.
- **Full contention:** all 5 FUs send tags 1..5 with `rr_ptr`=0.
  - Broadcast 1: slots = tags 1, 2, 3; `fu_ready[3:4]`=0.
  - Broadcast 2: slots = tags 4, 5, then invalid; `rr_ptr`=0.
- **Wrap-around:** `rr_ptr`=4 with FU4, FU0 and FU1 pending → slot0 = FU4, slot1 = FU0, slot2 = FU1; `rr_ptr`=2.
- **Streaming:** FU0 sends tags 10, 11, 12 on consecutive cycles with no other traffic → `fu_ready[0]` stays 1, and slot0 shows 10, 11, 12 on consecutive cycles with no bubble.
- **Squash:** 4 holds pending plus a new `fu_valid` on FU1 during `squash` → next cycle `cdb_valid`=000 and all holds empty; the FU1 result never appears on the bus.

Source files
------------

// File: rtl/cdb_broadcaster.sv
// Common Data Bus producer: per-FU one-entry holding registers, a round-robin
// arbiter granting up to CDB_WIDTH results per cycle, and a registered CDB.
module cdb_broadcaster #(
    parameter int NUM_FU    = 5,
    parameter int CDB_WIDTH = 3,
    parameter int ROBLEN    = 32,
    parameter int XLEN      = 32,
    parameter int TAG_W     = $clog2(ROBLEN),
    parameter int DATA_W    = XLEN
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               squash,
    input  logic [NUM_FU-1:0]                  fu_valid,
    input  logic [NUM_FU-1:0][TAG_W-1:0]       fu_tag,
    input  logic [NUM_FU-1:0][DATA_W-1:0]      fu_value,
    output logic [NUM_FU-1:0]                  fu_ready,
    output logic [CDB_WIDTH-1:0]               cdb_valid,
    output logic [CDB_WIDTH-1:0][TAG_W-1:0]    cdb_tag,
    output logic [CDB_WIDTH-1:0][DATA_W-1:0]   cdb_value
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]                  hold_valid;
    logic [NUM_FU-1:0][TAG_W-1:0]       hold_tag;
    logic [NUM_FU-1:0][DATA_W-1:0]      hold_value;
    logic [PTR_W-1:0]                   rr_ptr;
    logic [PTR_W-1:0]                   rr_next;
    logic [NUM_FU-1:0]                  grant;
    logic [CDB_WIDTH-1:0]               slot_used;
    logic [CDB_WIDTH-1:0][PTR_W-1:0]    slot_sel;

    // Scan from rr_ptr with wrap; the k-th pending entry found lands in slot k.
    always_comb begin
        int               idx;
        int               cnt;
        int               last;
        logic [PTR_W-1:0] idx_p;
        grant     = '0;
        slot_used = '0;
        slot_sel  = '0;
        idx       = 0;
        idx_p     = '0;
        cnt       = 0;
        last      = int'(rr_ptr);
        for (int j = 0; j < NUM_FU; j++) begin
            idx = int'(rr_ptr) + j;
            if (idx >= NUM_FU) begin
                idx = idx - NUM_FU;
            end
            idx_p = PTR_W'(idx);
            if (hold_valid[idx_p] && (cnt < CDB_WIDTH)) begin
                grant[idx_p] = 1'b1;
                for (int k = 0; k < CDB_WIDTH; k++) begin
                    if (k == cnt) begin
                        slot_used[k] = 1'b1;
                        slot_sel[k]  = idx_p;
                    end
                end
                cnt  = cnt + 1;
                last = idx;
            end
        end
        if (cnt == 0) begin
            rr_next = rr_ptr;
        end else if (last == NUM_FU - 1) begin
            rr_next = '0;
        end else begin
            rr_next = PTR_W'(last + 1);
        end
    end

    // A granted entry frees its holding register this cycle, so it can reload with no bubble.
    assign fu_ready = ~{NUM_FU{squash}} & (~hold_valid | grant);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_valid <= '0;
            hold_tag   <= '0;
            hold_value <= '0;
        end else if (squash) begin
            hold_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    hold_valid[i] <= 1'b1;
                    hold_tag[i]   <= fu_tag[i];
                    hold_value[i] <= fu_value[i];
                end else if (grant[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb_valid <= '0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            rr_ptr    <= '0;
        end else if (squash) begin
            cdb_valid <= '0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            rr_ptr    <= '0;
        end else begin
            for (int k = 0; k < CDB_WIDTH; k++) begin
                cdb_valid[k] <= slot_used[k];
                cdb_tag[k]   <= slot_used[k] ? hold_tag[slot_sel[k]]   : '0;
                cdb_value[k] <= slot_used[k] ? hold_value[slot_sel[k]] : '0;
            end
            rr_ptr <= rr_next;
        end
    end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed, table-driven bench for cdb_broadcaster with hand-computed expectations,
// plus a hand-written mid-stream reset sequence.
module tb_cdb_broadcaster;

    logic              clock;
    logic              reset;
    logic              squash;
    logic [4:0]        fu_valid;
    logic [4:0][4:0]   fu_tag;
    logic [4:0][31:0]  fu_value;
    logic [4:0]        fu_ready;
    logic [2:0]        cdb_valid;
    logic [2:0][4:0]   cdb_tag;
    logic [2:0][31:0]  cdb_value;

    int total = 0;
    int bad   = 0;

    cdb_broadcaster #(
        .NUM_FU    (5),
        .CDB_WIDTH (3),
        .ROBLEN    (32),
        .XLEN      (32)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .squash    (squash),
        .fu_valid  (fu_valid),
        .fu_tag    (fu_tag),
        .fu_value  (fu_value),
        .fu_ready  (fu_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string             name;
        logic              sq;
        logic [4:0]        v;
        logic [4:0][4:0]   tag;
        logic [4:0][31:0]  val;
        logic [4:0]        rdy;
        logic [2:0]        cv;
        logic [2:0][4:0]   ct;
        logic [2:0][31:0]  cval;
        logic [2:0]        rr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] mkval(int fu, int tag);
        return 32'hA500_0000 | (32'(fu) << 16) | 32'(tag);
    endfunction

    // Slot fu index -1 marks an unused slot.
    function automatic vec_t mk(string name, logic sq, logic [4:0] v,
                                int t0, int t1, int t2, int t3, int t4,
                                logic [4:0] rdy,
                                int f0, int g0, int f1, int g1, int f2, int g2,
                                int rr);
        vec_t r;
        int t[5];
        int f[3];
        int g[3];
        t = '{t0, t1, t2, t3, t4};
        f = '{f0, f1, f2};
        g = '{g0, g1, g2};
        r.name = name;
        r.sq   = sq;
        r.v    = v;
        r.rdy  = rdy;
        r.rr   = 3'(rr);
        for (int i = 0; i < 5; i++) begin
            if (v[i]) begin
                r.tag[i] = 5'(t[i]);
                r.val[i] = mkval(i, t[i]);
            end else begin
                r.tag[i] = 5'd31;
                r.val[i] = 32'hBAD0_0000;
            end
        end
        for (int s = 0; s < 3; s++) begin
            if (f[s] >= 0) begin
                r.cv[s]   = 1'b1;
                r.ct[s]   = 5'(g[s]);
                r.cval[s] = mkval(f[s], g[s]);
            end else begin
                r.cv[s]   = 1'b0;
                r.ct[s]   = 5'd0;
                r.cval[s] = 32'd0;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        vec_t r;
        reset    = 1'b0;
        squash   = 1'b0;
        fu_valid = '0;
        fu_tag   = '0;
        fu_value = '0;

        // name              sq  valid     t0  t1  t2  t3  t4  ready     s0      s1      s2      rr
        r = mk("single_hs",   0, 5'b00100,  0,  0,  7,  0,  0, 5'b11111, -1, 0, -1, 0, -1, 0, 0);
        r.val[2] = 32'hDEADBEEF;
        vecs.push_back(r);
        r = mk("single_bus",  0, 5'b00000,  0,  0,  0,  0,  0, 5'b11111,  2, 7, -1, 0, -1, 0, 3);
        r.cval[0] = 32'hDEADBEEF;
        vecs.push_back(r);
        vecs.push_back(mk("single_idle",   0, 5'b00000,  0,  0,  0,  0,  0, 5'b11111, -1, 0, -1, 0, -1, 0, 3));
        vecs.push_back(mk("squash_empty",  1, 5'b00000,  0,  0,  0,  0,  0, 5'b00000, -1, 0, -1, 0, -1, 0, 0));
        vecs.push_back(mk("contend_load",  0, 5'b11111,  1,  2,  3,  4,  5, 5'b11111, -1, 0, -1, 0, -1, 0, 0));
        vecs.push_back(mk("contend_b1",    0, 5'b01000,  0,  0,  0,  9,  0, 5'b00111,  0, 1,  1, 2,  2, 3, 3));
        vecs.push_back(mk("contend_b2",    0, 5'b01000,  0,  0,  0,  9,  0, 5'b11111,  3, 4,  4, 5, -1, 0, 0));
        vecs.push_back(mk("wrap_load",     0, 5'b10011, 21, 22,  0,  0, 20, 5'b11111,  3, 9, -1, 0, -1, 0, 4));
        vecs.push_back(mk("wrap_bus",      0, 5'b00000,  0,  0,  0,  0,  0, 5'b11111,  4, 20, 0, 21, 1, 22, 2));
        vecs.push_back(mk("wrap_idle",     0, 5'b00000,  0,  0,  0,  0,  0, 5'b11111, -1, 0, -1, 0, -1, 0, 2));
        vecs.push_back(mk("stream_10",     0, 5'b00001, 10,  0,  0,  0,  0, 5'b11111, -1, 0, -1, 0, -1, 0, 2));
        vecs.push_back(mk("stream_11",     0, 5'b00001, 11,  0,  0,  0,  0, 5'b11111,  0, 10, -1, 0, -1, 0, 1));
        vecs.push_back(mk("stream_12",     0, 5'b00001, 12,  0,  0,  0,  0, 5'b11111,  0, 11, -1, 0, -1, 0, 1));
        vecs.push_back(mk("stream_drain",  0, 5'b00000,  0,  0,  0,  0,  0, 5'b11111,  0, 12, -1, 0, -1, 0, 1));
        vecs.push_back(mk("stream_idle",   0, 5'b00000,  0,  0,  0,  0,  0, 5'b11111, -1, 0, -1, 0, -1, 0, 1));
        vecs.push_back(mk("squash_load",   0, 5'b11101, 30,  0, 32, 33, 34, 5'b11111, -1, 0, -1, 0, -1, 0, 1));
        vecs.push_back(mk("squash_hit",    1, 5'b00010,  0, 31,  0,  0,  0, 5'b00000, -1, 0, -1, 0, -1, 0, 0));
        vecs.push_back(mk("squash_after",  0, 5'b00000,  0,  0,  0,  0,  0, 5'b11111, -1, 0, -1, 0, -1, 0, 0));
        vecs.push_back(mk("squash_idle",   0, 5'b00000,  0,  0,  0,  0,  0, 5'b11111, -1, 0, -1, 0, -1, 0, 0));
        vecs.push_back(mk("tag_zero_hs",   0, 5'b00100,  0,  0,  0,  0,  0, 5'b11111, -1, 0, -1, 0, -1, 0, 0));
        vecs.push_back(mk("tag_zero_bus",  0, 5'b00000,  0,  0,  0,  0,  0, 5'b11111,  2, 0, -1, 0, -1, 0, 3));

        // Reset state while reset is held.
        #12;
        chk("rst_cdb_valid", 128'(cdb_valid), 128'(3'b000));
        chk("rst_cdb_tag",   128'(cdb_tag),   128'(15'd0));
        chk("rst_cdb_value", 128'(cdb_value), 128'(96'd0));
        chk("rst_fu_ready",  128'(fu_ready),  128'(5'b11111));
        chk("rst_rr_ptr",    128'(dut.rr_ptr), 128'(3'd0));
        reset = 1'b1;

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge clock);
            squash   = vecs[n].sq;
            fu_valid = vecs[n].v;
            fu_tag   = vecs[n].tag;
            fu_value = vecs[n].val;
            #1;
            chk({vecs[n].name, ".fu_ready"}, 128'(fu_ready), 128'(vecs[n].rdy));
            @(posedge clock);
            #1;
            chk({vecs[n].name, ".cdb_valid"}, 128'(cdb_valid), 128'(vecs[n].cv));
            chk({vecs[n].name, ".cdb_tag"},   128'(cdb_tag),   128'(vecs[n].ct));
            chk({vecs[n].name, ".cdb_value"}, 128'(cdb_value), 128'(vecs[n].cval));
            chk({vecs[n].name, ".rr_ptr"},    128'(dut.rr_ptr), 128'(vecs[n].rr));
        end

        // Mid-stream reset: bus full and three holds pending, then async reset.
        @(negedge clock);
        squash   = 1'b0;
        fu_valid = 5'b11111;
        for (int i = 0; i < 5; i++) begin
            fu_tag[i]   = 5'(50 + i);
            fu_value[i] = mkval(i, 50 + i);
        end
        @(posedge clock);
        @(negedge clock);
        fu_valid    = 5'b00001;
        fu_tag[0]   = 5'd55;
        fu_value[0] = mkval(0, 55);
        @(posedge clock);
        #1;
        chk("prerst_cdb_valid", 128'(cdb_valid), 128'(3'b111));
        @(negedge clock);
        fu_valid = '0;
        reset    = 1'b0;
        #1;
        chk("midrst_cdb_valid", 128'(cdb_valid), 128'(3'b000));
        chk("midrst_cdb_tag",   128'(cdb_tag),   128'(15'd0));
        chk("midrst_cdb_value", 128'(cdb_value), 128'(96'd0));
        chk("midrst_rr_ptr",    128'(dut.rr_ptr), 128'(3'd0));
        #1;
        reset = 1'b1;
        #1;
        chk("postrst_fu_ready", 128'(fu_ready), 128'(5'b11111));
        @(posedge clock);
        #1;
        chk("postrst_no_stale", 128'(cdb_valid), 128'(3'b000));
        @(negedge clock);
        fu_valid    = 5'b10000;
        fu_tag[4]   = 5'd60;
        fu_value[4] = mkval(4, 60);
        @(posedge clock);
        #1;
        chk("postrst_hs_valid", 128'(cdb_valid), 128'(3'b000));
        @(negedge clock);
        fu_valid = '0;
        @(posedge clock);
        #1;
        chk("postrst_bus_valid", 128'(cdb_valid),    128'(3'b001));
        chk("postrst_bus_tag",   128'(cdb_tag[0]),   128'(5'd60));
        chk("postrst_bus_value", 128'(cdb_value[0]), 128'(mkval(4, 60)));
        chk("postrst_rr_ptr",    128'(dut.rr_ptr),   128'(3'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
